// File: rtl/bsg_tag_cfg_sequencer.sv
// bsg_tag master: arbitrates cfg requesters, shifts one tag packet per grant (BSG_TAG_CFG_SEQ_ROUND_ROBIN_EN selects round-robin).
// Latency: yumi_o in cycle t, start bit on tag_data_o in cycle t+1; packet is 2+lg_w_lp+lg_els_lp+len bits.
// Backpressure: requests wait (no yumi) during INIT, packet and gap; v_i may drop before yumi at no cost.
module bsg_tag_cfg_sequencer #(
    parameter int num_req_p     = 4,
    parameter int els_p         = 4,
    parameter int max_payload_p = 8,
    parameter int init_idle_p   = 16,
    parameter int gap_p         = 2,
    localparam int lg_els_lp    = $clog2(els_p + 1),
    localparam int lg_w_lp      = $clog2(max_payload_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               v_i,
    input  logic [num_req_p*lg_els_lp-1:0]     id_i,
    input  logic [num_req_p-1:0]               dnr_i,
    input  logic [num_req_p*lg_w_lp-1:0]       len_i,
    input  logic [num_req_p*max_payload_p-1:0] data_i,
    output logic [num_req_p-1:0]               yumi_o,
    output logic                               tag_en_o,
    output logic                               tag_data_o,
    output logic                               busy_o,
    output logic                               len_err_o
);

    localparam int hdr_bits_lp = 2 + lg_w_lp + lg_els_lp;
    localparam int pkt_bits_lp = hdr_bits_lp + max_payload_p;
    localparam int cnt_w_lp    = $clog2(pkt_bits_lp + 1);
    localparam int init_w_lp   = $clog2(init_idle_p + 1);
    localparam int gap_w_lp    = $clog2(gap_p + 1);
    localparam int lg_req_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_HDR, S_PAY, S_GAP} state_e;

    state_e                 state_r;
    logic [init_w_lp-1:0]   idle_cnt_r;
    logic [gap_w_lp-1:0]    gap_cnt_r;
    logic [cnt_w_lp-1:0]    bit_cnt_r;
    logic [cnt_w_lp-1:0]    total_r;
    logic [pkt_bits_lp-2:0] pkt_sr_r;
    logic                   tag_en_r;
    logic                   tag_data_r;
    logic                   len_err_r;

    logic [lg_req_lp-1:0]     win_idx;
    logic                     win_found;
    logic [lg_els_lp-1:0]     win_id;
    logic                     win_dnr;
    logic [lg_w_lp-1:0]       win_len_raw;
    logic [lg_w_lp-1:0]       win_len;
    logic [max_payload_p-1:0] win_data;
    logic                     len_over;
    logic                     accept;

`ifdef BSG_TAG_CFG_SEQ_ROUND_ROBIN_EN
    // Search starts just after the last winner, so it drops to lowest priority.
    logic [lg_req_lp-1:0] last_win_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            last_win_r <= lg_req_lp'(num_req_p - 1);
        else if (accept)
            last_win_r <= win_idx;
    end

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!win_found && v_i[(int'(last_win_r) + 1 + i) % num_req_p]) begin
                win_found = 1'b1;
                win_idx   = lg_req_lp'((int'(last_win_r) + 1 + i) % num_req_p);
            end
        end
    end
`else
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (v_i[i]) begin
                win_found = 1'b1;
                win_idx   = lg_req_lp'(i);
            end
        end
    end
`endif

    assign win_id      = id_i[win_idx*lg_els_lp +: lg_els_lp];
    assign win_dnr     = dnr_i[win_idx];
    assign win_len_raw = len_i[win_idx*lg_w_lp +: lg_w_lp];
    assign win_data    = data_i[win_idx*max_payload_p +: max_payload_p];
    assign len_over    = win_len_raw > lg_w_lp'(max_payload_p);
    assign win_len     = len_over ? lg_w_lp'(max_payload_p) : win_len_raw;
    assign accept      = (state_r == S_IDLE) && win_found;

    always_comb begin
        yumi_o = '0;
        if (accept)
            yumi_o[win_idx] = 1'b1;
    end

    // Start bit goes straight to the output register; the rest of the packet is
    // held LSB-first in pkt_sr_r and bit_cnt_r is the index of the next bit out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= S_INIT;
            idle_cnt_r <= '0;
            gap_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            total_r    <= '0;
            pkt_sr_r   <= '0;
            tag_en_r   <= 1'b0;
            tag_data_r <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (idle_cnt_r == init_w_lp'(init_idle_p - 1))
                        state_r <= S_IDLE;
                    else
                        idle_cnt_r <= idle_cnt_r + init_w_lp'(1);
                end
                S_IDLE: begin
                    if (accept) begin
                        tag_en_r   <= 1'b1;
                        tag_data_r <= 1'b1;
                        pkt_sr_r   <= {win_data, win_dnr, win_id, win_len};
                        bit_cnt_r  <= cnt_w_lp'(1);
                        total_r    <= cnt_w_lp'(hdr_bits_lp) + cnt_w_lp'(win_len);
                        len_err_r  <= len_err_r | len_over;
                        state_r    <= S_HDR;
                    end
                end
                S_HDR, S_PAY: begin
                    if (bit_cnt_r < total_r) begin
                        tag_data_r <= pkt_sr_r[0];
                        pkt_sr_r   <= pkt_sr_r >> 1;
                        bit_cnt_r  <= bit_cnt_r + cnt_w_lp'(1);
                        state_r    <= (bit_cnt_r >= cnt_w_lp'(hdr_bits_lp)) ? S_PAY : S_HDR;
                    end else begin
                        tag_en_r   <= 1'b0;
                        tag_data_r <= 1'b0;
                        gap_cnt_r  <= '0;
                        state_r    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == gap_w_lp'(gap_p - 1))
                        state_r <= S_IDLE;
                    else
                        gap_cnt_r <= gap_cnt_r + gap_w_lp'(1);
                end
                default: state_r <= S_INIT;
            endcase
        end
    end

    assign tag_en_o   = tag_en_r;
    assign tag_data_o = tag_data_r;
    assign len_err_o  = len_err_r;
    assign busy_o     = (state_r == S_HDR) || (state_r == S_PAY) || (state_r == S_GAP);

endmodule

// File: tb/tb_bsg_tag_cfg_sequencer.sv
// Scoreboard bench for bsg_tag_cfg_sequencer: stimulus queues expected grants/packets, a monitor pops and compares.
module tb_bsg_tag_cfg_sequencer;
    localparam int num_req_p     = 4;
    localparam int els_p         = 4;
    localparam int max_payload_p = 8;
    localparam int init_idle_p   = 16;
    localparam int gap_p         = 2;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [3:0]  v_i = '0;
    logic [11:0] id_i = '0;
    logic [3:0]  dnr_i = '0;
    logic [15:0] len_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  yumi_o;
    logic        tag_en_o;
    logic        tag_data_o;
    logic        busy_o;
    logic        len_err_o;

    int checks = 0;
    int failures = 0;

    logic [3:0]  exp_yumi_q[$];
    logic [31:0] exp_bits_q[$];
    int          exp_n_q[$];

    bsg_tag_cfg_sequencer #(
        .num_req_p(num_req_p), .els_p(els_p), .max_payload_p(max_payload_p),
        .init_idle_p(init_idle_p), .gap_p(gap_p)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .id_i(id_i), .dnr_i(dnr_i),
        .len_i(len_i), .data_i(data_i), .yumi_o(yumi_o), .tag_en_o(tag_en_o),
        .tag_data_o(tag_data_o), .busy_o(busy_o), .len_err_o(len_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: start | len(4) | id(3) | dnr | payload, emitted LSB-first.
    function automatic logic [31:0] pkt_model(input int id, input int dnr, input int len, input logic [7:0] data);
        int l;
        logic [31:0] d;
        l = (len > max_payload_p) ? max_payload_p : len;
        d = 32'(data) & ((32'd1 << l) - 32'd1);
        return 32'd1 | (32'(l) << 1) | (32'(id) << 5) | (32'(dnr) << 8) | (d << 9);
    endfunction

    task automatic expect_pkt(input int r, input int id, input int dnr, input int len, input logic [7:0] data);
        exp_yumi_q.push_back(4'(1 << r));
        exp_bits_q.push_back(pkt_model(id, dnr, len, data));
        exp_n_q.push_back(9 + ((len > max_payload_p) ? max_payload_p : len));
    endtask

    task automatic set_fields(input int r, input int id, input int dnr, input int len, input logic [7:0] data);
        id_i[r*3 +: 3]  = 3'(id);
        dnr_i[r]        = 1'(dnr);
        len_i[r*4 +: 4] = 4'(len);
        data_i[r*8 +: 8] = data;
    endtask

    task automatic drive_req(input int r, input int id, input int dnr, input int len, input logic [7:0] data);
        int n;
        set_fields(r, id, dnr, len, data);
        v_i[r] = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk_i);
            if (yumi_o[r]) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL req%0d_grant_timeout actual=no_yumi required=yumi", r);
        end
        @(posedge clk_i);
        #1;
        v_i[r] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_o || tag_en_o) && n < 400) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n >= 400), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // Monitor: grants, packet reassembly, idle-line and gap checks.
    logic [31:0] cur_bits = '0;
    int          cur_n = 0;
    int          zero_run = 100;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            chk("reset_tag_en", tag_en_o, 0);
            chk("reset_tag_data", tag_data_o, 0);
            cur_n = 0;
            cur_bits = '0;
            zero_run = 100;
        end else begin
            if (yumi_o != 4'b0) begin
                chk("yumi_not_busy", busy_o, 0);
                if (exp_yumi_q.size() == 0)
                    chk("yumi_unexpected", yumi_o, 0);
                else
                    chk("yumi_grant", yumi_o, exp_yumi_q.pop_front());
            end
            if (tag_en_o) begin
                if (cur_n == 0)
                    chk("gap_len_ok", 32'(zero_run >= gap_p), 1);
                chk("busy_in_pkt", busy_o, 1);
                if (cur_n < 32)
                    cur_bits[cur_n] = tag_data_o;
                cur_n++;
                zero_run = 0;
            end else begin
                chk("data_idle_zero", tag_data_o, 0);
                if (cur_n > 0) begin
                    if (exp_n_q.size() == 0) begin
                        chk("pkt_unexpected", 32'(cur_n), 0);
                    end else begin
                        chk("pkt_len", 32'(cur_n), 32'(exp_n_q.pop_front()));
                        chk("pkt_bits", cur_bits, exp_bits_q.pop_front());
                    end
                    cur_n = 0;
                    cur_bits = '0;
                end
                zero_run++;
            end
        end
    end

    initial begin
        int n;
        logic [31:0] dummy;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_yumi", yumi_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_len_err", len_err_o, 0);
        reset_n_i = 1'b1;

        // 1: no requests, line stays quiet through init and beyond
        repeat (init_idle_p + 8) @(posedge clk_i);
        #1;
        chk("t1_busy", busy_o, 0);
        chk("t1_tag_en", tag_en_o, 0);

        // 2: hand-built 14-bit packet 1,1010,010,1,01101
        exp_yumi_q.push_back(4'b0001);
        exp_bits_q.push_back(32'b10110101001011);
        exp_n_q.push_back(14);
        drive_req(0, 2, 1, 5, 8'b10110);
        drain();

        // 3: all four requesters at once, granted lowest index first
        expect_pkt(0, 1, 0, 3, 8'h05);
        expect_pkt(1, 2, 1, 4, 8'h0A);
        expect_pkt(2, 3, 0, 1, 8'h01);
        expect_pkt(3, 4, 1, 8, 8'hC3);
        fork
            drive_req(0, 1, 0, 3, 8'h05);
            drive_req(1, 2, 1, 4, 8'h0A);
            drive_req(2, 3, 0, 1, 8'h01);
            drive_req(3, 4, 1, 8, 8'hC3);
        join
        drain();

        // 4: zero-length packet is header only
        expect_pkt(1, 1, 0, 0, 8'hFF);
        drive_req(1, 1, 0, 0, 8'hFF);
        drain();
        chk("t4_len_err", len_err_o, 0);

        // 5: over-long request clamps to max_payload_p, sticky error
        expect_pkt(2, 3, 1, 12, 8'hA5);
        drive_req(2, 3, 1, 12, 8'hA5);
        drain();
        chk("t5_len_err", len_err_o, 1);
        expect_pkt(3, 2, 0, 2, 8'h02);
        drive_req(3, 2, 0, 2, 8'h02);
        drain();
        chk("t5_len_err_sticky", len_err_o, 1);

        // 6: reset mid-payload aborts at once, then request is re-granted after init
        expect_pkt(0, 2, 1, 8, 8'h5A);
        drive_req(0, 2, 1, 8, 8'h5A);
        repeat (11) @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_abort_en", tag_en_o, 0);
        chk("t6_abort_data", tag_data_o, 0);
        chk("t6_abort_busy", busy_o, 0);
        chk("t6_len_err_cleared", len_err_o, 0);
        dummy = exp_bits_q.pop_back();
        n = exp_n_q.pop_back();
        expect_pkt(0, 2, 1, 8, 8'h5A);
        set_fields(0, 2, 1, 8, 8'h5A);
        v_i[0] = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk_i);
            if (yumi_o[0]) break;
            n++;
        end
        chk("t6_init_idle_cycles", 32'(n), 32'(init_idle_p));
        @(posedge clk_i);
        #1;
        v_i[0] = 1'b0;
        drain();

        chk("end_yumi_q_empty", 32'(exp_yumi_q.size()), 0);
        chk("end_pkt_q_empty", 32'(exp_n_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
